// File: rtl/sysbus_mem_responder.sv
// ============================================================================
// Module   : sysbus_mem_responder
// Brief    : System-bus memory target; line-sized reads/writes to a 64-bit-word
//            backing store, read data returned as tagged response bursts.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sysbus_mem_responder #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = 8,
    parameter int MEM_WORDS      = 4096,
    parameter int READ_LATENCY   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    output logic                      bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_respcyc,
    input  logic                      bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

    localparam int WIW = BUS_DATA_WIDTH - 3;
    localparam int AW  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int CW  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LW  = $clog2(READ_LATENCY + 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_WDATA = 2'd1;
    localparam logic [1:0] c_RWAIT = 2'd2;
    localparam logic [1:0] c_RRESP = 2'd3;

    logic [1:0]                state_q, state_d;
    logic [WIW-1:0]            base_q,  base_d;
    logic [CW-1:0]             cnt_q,   cnt_d;
    logic [LW-1:0]             lat_q,   lat_d;
    logic [BUS_TAG_WIDTH-1:0]  tag_q,   tag_d;
    logic [BUS_DATA_WIDTH-1:0] resp_q,  resp_d;

    logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic [WIW-1:0]            w_hdr_base;
    logic [WIW-1:0]            w_beat_word;
    logic [WIW-1:0]            w_fetch_word;
    logic [BUS_DATA_WIDTH-1:0] w_fetch_data;
    logic                      w_req_xfer;
    logic                      w_last_beat;
    logic                      w_mem_we;
    logic                      w_unused;

    // Byte offset within a word carries no meaning for line transfers.
    assign w_unused     = ^bus_req[2:0];
    assign w_hdr_base   = bus_req[BUS_DATA_WIDTH-1:3] & ~WIW'(BEATS - 1);
    assign w_beat_word  = base_q + WIW'(cnt_q);
    assign w_last_beat  = (cnt_q == CW'(BEATS - 1));
    assign w_req_xfer   = bus_reqcyc && bus_reqack;

    // Prefetch the beat that will be presented next: beat 0 while waiting, else beat+1.
    assign w_fetch_word = (state_q == c_RRESP) ? (w_beat_word + WIW'(1)) : base_q;
    assign w_fetch_data = (w_fetch_word < WIW'(MEM_WORDS)) ? mem[w_fetch_word[AW-1:0]]
                                                            : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= c_IDLE;
            base_q  <= '0;
            cnt_q   <= '0;
            lat_q   <= '0;
            tag_q   <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            tag_q   <= tag_d;
            resp_q  <= resp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        tag_d   = tag_q;
        resp_d  = resp_q;
        case (state_q)
            c_IDLE: begin
                if (w_req_xfer) begin
                    base_d = w_hdr_base;
                    tag_d  = bus_reqtag;
                    cnt_d  = '0;
                    if (bus_reqtag[BUS_TAG_WIDTH-1]) begin
                        state_d = c_WDATA;
                    end else begin
                        state_d = c_RWAIT;
                        lat_d   = LW'(READ_LATENCY - 1);
                    end
                end
            end
            c_WDATA: begin
                if (w_req_xfer) begin
                    cnt_d = cnt_q + CW'(1);
                    if (w_last_beat) begin
                        state_d = c_IDLE;
                    end
                end
            end
            c_RWAIT: begin
                if (lat_q == '0) begin
                    state_d = c_RRESP;
                    cnt_d   = '0;
                    resp_d  = w_fetch_data;
                end else begin
                    lat_d = lat_q - LW'(1);
                end
            end
            c_RRESP: begin
                if (bus_respack) begin
                    if (w_last_beat) begin
                        state_d = c_IDLE;
                    end else begin
                        cnt_d  = cnt_q + CW'(1);
                        resp_d = w_fetch_data;
                    end
                end
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_comb begin
        bus_reqack  = reset && bus_reqcyc && ((state_q == c_IDLE) || (state_q == c_WDATA));
        bus_respcyc = (state_q == c_RRESP);
        bus_resp    = resp_q;
        bus_resptag = tag_q;
        w_mem_we    = (state_q == c_WDATA) && w_req_xfer && (w_beat_word < WIW'(MEM_WORDS));
    end

    // Backing store deliberately has no reset so contents survive a bus reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem[w_beat_word[AW-1:0]] <= bus_req;
        end
    end

endmodule

`default_nettype wire
